// File: rtl/pixel_group_collector.sv
`default_nettype none
// ============================================================================
// Module      : pixel_group_collector
// Description : Packs a tagged RGB pixel stream into 8-pixel (192-bit) groups
//               and hands them downstream over valid/ready. A fill bank and an
//               output bank give one group of stall slack. Tracks each group's
//               position within the frame and flags address-sequence errors.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_group_collector #(
    parameter int unsigned GROUPS_PER_FRAME = 38400,
    parameter int unsigned INDEX_W          = 16
) (
    input  logic                 clock,
    input  logic                 neg_reset,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [7:0]           red_in,
    input  logic [7:0]           green_in,
    input  logic [7:0]           blue_in,
    input  logic [2:0]           rel_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [191:0]         out_data,
    output logic [INDEX_W-1:0]   out_group_index,
    output logic                 out_frame_end,
    input  logic                 clear_error,
    output logic                 seq_error
);

    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(GROUPS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // output bank empty
        ST_ONE   = 2'd1,   // output bank valid, fill bank filling
        ST_FULL  = 2'd2    // output bank valid, fill bank holds a complete group
    } state_t;

    state_t                 state_q;
    logic [7:0][23:0]       fill_q;
    logic [7:0][23:0]       fill_d;
    logic [191:0]           out_data_q;
    logic [INDEX_W-1:0]     out_group_index_q;
    logic                   out_frame_end_q;
    logic [INDEX_W-1:0]     group_ctr_q;
    logic [2:0]             exp_addr_q;
    logic                   seq_error_q;

    logic                   w_accept;
    logic                   w_complete;
    logic                   w_handshake;
    logic                   w_move;

    // Ready depends only on registered state (and reset), never on out_ready.
    assign pix_ready   = (state_q != ST_FULL) && neg_reset;
    assign w_accept    = pix_valid && pix_ready;
    assign w_complete  = w_accept && (rel_addr == 3'd7);
    assign w_handshake = out_valid && out_ready;

    // The fill bank moves to the output bank whenever the output bank is free
    // (empty or being taken this cycle) and a complete group is available.
    assign w_move = ((state_q == ST_EMPTY) && w_complete)
                 || ((state_q == ST_ONE)   && w_complete && w_handshake)
                 || ((state_q == ST_FULL)  && w_handshake);

    // Fill bank contents including the pixel accepted this cycle.
    always_comb begin
        fill_d = fill_q;
        if (w_accept) begin
            fill_d[rel_addr] = {red_in, green_in, blue_in};
        end
    end

    // Controller, fill/output banks, frame position and sequence checking.
    always_ff @(posedge clock or negedge neg_reset) begin
        if (!neg_reset) begin
            state_q           <= ST_EMPTY;
            fill_q            <= '0;
            out_data_q        <= '0;
            out_group_index_q <= '0;
            out_frame_end_q   <= 1'b0;
            group_ctr_q       <= '0;
            exp_addr_q        <= 3'd0;
            seq_error_q       <= 1'b0;
        end else begin
            if (w_accept) begin
                exp_addr_q <= rel_addr + 3'd1;
            end

            // A new error takes priority over a coincident clear.
            if (w_accept && (rel_addr != exp_addr_q)) begin
                seq_error_q <= 1'b1;
            end else if (clear_error) begin
                seq_error_q <= 1'b0;
            end

            // Groups leave the fill bank in completion order, so tagging at
            // the move gives each group the same index as tagging at completion.
            if (w_move) begin
                out_data_q        <= fill_d;
                out_group_index_q <= group_ctr_q;
                out_frame_end_q   <= (group_ctr_q == LAST_IDX);
                group_ctr_q       <= (group_ctr_q == LAST_IDX) ? '0
                                                               : group_ctr_q + INDEX_W'(1);
                fill_q            <= '0;
            end else begin
                fill_q            <= fill_d;
            end

            case (state_q)
                ST_EMPTY: begin
                    if (w_complete) state_q <= ST_ONE;
                end
                ST_ONE: begin
                    if (w_complete && !w_handshake) begin
                        state_q <= ST_FULL;
                    end else if (!w_complete && w_handshake) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_handshake) state_q <= ST_ONE;
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign out_valid       = (state_q != ST_EMPTY);
    assign out_data        = out_data_q;
    assign out_group_index = out_group_index_q;
    assign out_frame_end   = out_frame_end_q;
    assign seq_error       = seq_error_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_group_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_group_collector
// Description : Scoreboard bench for pixel_group_collector (4 groups/frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_group_collector;

    localparam int GPF = 4;
    localparam int IW  = 16;

    logic           clock = 1'b0;
    logic           neg_reset = 1'b1;
    logic           pix_valid = 1'b0;
    logic           pix_ready;
    logic [7:0]     red_in = '0;
    logic [7:0]     green_in = '0;
    logic [7:0]     blue_in = '0;
    logic [2:0]     rel_addr = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [191:0]   out_data;
    logic [IW-1:0]  out_group_index;
    logic           out_frame_end;
    logic           clear_error = 1'b0;
    logic           seq_error;

    pixel_group_collector #(
        .GROUPS_PER_FRAME (GPF),
        .INDEX_W          (IW)
    ) u_dut (
        .clock           (clock),
        .neg_reset       (neg_reset),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .red_in          (red_in),
        .green_in        (green_in),
        .blue_in         (blue_in),
        .rel_addr        (rel_addr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_group_index (out_group_index),
        .out_frame_end   (out_frame_end),
        .clear_error     (clear_error),
        .seq_error       (seq_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [191:0]  data;
        logic [IW-1:0] idx;
        logic          fe;
    } grp_t;

    grp_t           sb_q[$];
    logic [191:0]   m_fill = '0;
    logic [IW-1:0]  m_idx  = '0;
    logic [2:0]     m_exp  = '0;
    logic           m_err  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] px(input int g, input int k);
        return 24'((g << 16) | (k << 8) | (g * 8 + k + 1));
    endfunction

    // Reference model update for one accepted beat.
    task automatic model_accept(input logic [2:0] a, input logic [23:0] p, input logic clr);
        grp_t g;
        if (a != m_exp) m_err = 1'b1;
        else if (clr)   m_err = 1'b0;
        m_exp = a + 3'd1;
        m_fill[int'(a) * 24 +: 24] = p;
        if (a == 3'd7) begin
            g.data = m_fill;
            g.idx  = m_idx;
            g.fe   = (int'(m_idx) == GPF - 1);
            sb_q.push_back(g);
            m_fill = '0;
            m_idx  = (int'(m_idx) == GPF - 1) ? '0 : m_idx + IW'(1);
        end
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [2:0] a, input logic [23:0] p);
        int t;
        t = 0;
        pix_valid = 1'b1;
        rel_addr  = a;
        {red_in, green_in, blue_in} = p;
        @(negedge clock);
        while (!pix_ready && t < 100) begin
            t++;
            @(negedge clock);
        end
        if (!pix_ready) check("beat_accept_timeout", 192'(pix_ready), 192'(1));
        else            model_accept(a, p, clear_error);
        @(posedge clock); #1;
        pix_valid   = 1'b0;
        clear_error = 1'b0;
    endtask

    task automatic send_group(input int g);
        for (int k = 0; k < 8; k++) send_beat(3'(k), px(g, k));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        check("drain_empty", 192'(sb_q.size()), 192'(0));
    endtask

    // Output monitor: compares delivered groups and checks hold-under-stall.
    logic          prev_stall = 1'b0;
    logic [191:0]  prev_data  = '0;
    logic [IW-1:0] prev_idx   = '0;
    logic          prev_fe    = 1'b0;

    always @(negedge clock) begin
        grp_t g;
        if (!neg_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_data", out_data, prev_data);
                check("hold_index", 192'(out_group_index), 192'(prev_idx));
                check("hold_fe", 192'(out_frame_end), 192'(prev_fe));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_group", 192'(1), 192'(0));
                end else begin
                    g = sb_q.pop_front();
                    check("group_data", out_data, g.data);
                    check("group_index", 192'(out_group_index), 192'(g.idx));
                    check("group_frame_end", 192'(out_frame_end), 192'(g.fe));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_group_index;
            prev_fe    = out_frame_end;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ---------------- reset ----------------
        #1 neg_reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_pix_ready", 192'(pix_ready), 192'(0));
        check("rst_out_valid", 192'(out_valid), 192'(0));
        check("rst_out_data", out_data, 192'(0));
        check("rst_index", 192'(out_group_index), 192'(0));
        check("rst_seq_error", 192'(seq_error), 192'(0));
        neg_reset = 1'b1;
        @(posedge clock); #1;
        check("post_rst_ready", 192'(pix_ready), 192'(1));

        // ---------------- basic group, latency ----------------
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send_beat(3'(k), 24'((k << 16) | ((2 * k) << 8) | (3 * k)));
            if (k == 6) check("lat_before_last", 192'(out_valid), 192'(0));
        end
        check("lat_valid", 192'(out_valid), 192'(1));
        check("lat_index", 192'(out_group_index), 192'(0));
        check("basic_seq_error", 192'(seq_error), 192'(0));
        @(posedge clock); #1;
        check("lat_single_cycle", 192'(out_valid), 192'(0));
        wait_drain();

        // ---------------- stall: two groups buffered, third throttled ----------------
        out_ready = 1'b0;
        send_group(10);
        for (int k = 0; k < 8; k++) begin
            send_beat(3'(k), px(11, k));
            if (k == 6) check("stall_ready_before_full", 192'(pix_ready), 192'(1));
        end
        check("stall_ready_low", 192'(pix_ready), 192'(0));
        check("stall_held_index", 192'(out_group_index), 192'(sb_q[0].idx));
        pix_valid = 1'b1;
        rel_addr  = 3'd0;
        {red_in, green_in, blue_in} = px(12, 0);
        repeat (3) @(posedge clock);
        #1;
        check("stall_ready_still_low", 192'(pix_ready), 192'(0));
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("leave_full_ready", 192'(pix_ready), 192'(1));
        check("leave_full_valid", 192'(out_valid), 192'(1));
        send_group(12);
        wait_drain();

        // ---------------- sequence errors ----------------
        begin
            int addrs[7] = '{0, 1, 3, 4, 5, 6, 7};
            for (int i = 0; i < 7; i++) begin
                send_beat(3'(addrs[i]), px(20, addrs[i]));
                check("seq_err_track", 192'(seq_error), 192'(m_err));
            end
        end
        check("seq_err_set", 192'(seq_error), 192'(1));
        clear_error = 1'b1;
        @(posedge clock); #1;
        clear_error = 1'b0;
        m_err = 1'b0;
        check("seq_err_cleared", 192'(seq_error), 192'(0));
        clear_error = 1'b1;
        send_beat(3'd5, px(21, 5));
        check("seq_err_set_wins", 192'(seq_error), 192'(1));
        send_beat(3'd6, px(21, 6));
        send_beat(3'd7, px(21, 7));
        clear_error = 1'b1;
        @(posedge clock); #1;
        clear_error = 1'b0;
        m_err = 1'b0;
        check("seq_err_cleared2", 192'(seq_error), 192'(0));
        wait_drain();

        // ---------------- ONE with completion and handshake together ----------------
        out_ready = 1'b0;
        send_group(30);
        for (int k = 0; k < 7; k++) send_beat(3'(k), px(31, k));
        out_ready = 1'b1;
        send_beat(3'd7, px(31, 7));
        check("one_ch_valid", 192'(out_valid), 192'(1));
        check("one_ch_ready", 192'(pix_ready), 192'(1));
        check("one_ch_index", 192'(out_group_index), 192'(sb_q[sb_q.size() - 1].idx));
        send_group(32);
        wait_drain();

        // ---------------- reset while FULL ----------------
        out_ready = 1'b0;
        send_group(40);
        for (int k = 1; k < 8; k++) send_beat(3'(k), px(41, k));
        check("full_before_reset", 192'(pix_ready), 192'(0));
        check("err_before_reset", 192'(seq_error), 192'(1));
        pix_valid = 1'b1;
        #2 neg_reset = 1'b0;
        #1;
        check("arst_out_valid", 192'(out_valid), 192'(0));
        check("arst_out_data", out_data, 192'(0));
        check("arst_index", 192'(out_group_index), 192'(0));
        check("arst_fe", 192'(out_frame_end), 192'(0));
        check("arst_seq_error", 192'(seq_error), 192'(0));
        check("arst_pix_ready", 192'(pix_ready), 192'(0));
        pix_valid = 1'b0;
        sb_q.delete();
        m_fill = '0;
        m_idx  = '0;
        m_exp  = '0;
        m_err  = 1'b0;
        repeat (2) @(posedge clock);
        #1 neg_reset = 1'b1;
        @(posedge clock); #1;

        // ---------------- frame wrap: indices 0,1,2,3,0 ----------------
        out_ready = 1'b1;
        send_group(50);
        check("fresh_index", 192'(out_group_index), 192'(0));
        for (int g = 51; g < 55; g++) send_group(g);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_group_collector.md
# pixel_group_collector

Collects the processed RGB pixel stream from the image-processing stage, one pixel per accepted beat tagged with its 3-bit relative pixel address. It assembles 8 pixels into a 192-bit group and hands each complete group downstream to the frame-buffer writer over a valid/ready handshake. Two-entry buffering (fill bank plus output bank) absorbs one group of downstream stall before pixel input is throttled. It also tracks group position within the frame and flags address-sequence errors.

## Interface
- GROUPS_PER_FRAME, 38400, groups per frame (640x480 / 8); group index wraps after GROUPS_PER_FRAME-1
- INDEX_W, 16, width of group index; must satisfy 2^INDEX_W >= GROUPS_PER_FRAME

Ports:
- clock  in  1  single clock, all logic on rising edge
- neg_reset  in  1  reset, asynchronous, active-low
- pix_valid  in  1  pixel beat present
- pix_ready  out  1  collector accepts beat this cycle
- red_in, green_in, blue_in  in  8 each  processed pixel components
- rel_addr  in  3  slot (0..7) of this pixel within its group
- out_valid  out  1  group available
- out_ready  in  1  downstream accepts group
- out_data  out  192  packed group; slot k = out_data[24k+23:24k] = {R,G,B}
- out_group_index  out  INDEX_W  frame-relative index of presented group
- out_frame_end  out  1  presented group is last of frame
- clear_error  in  1  one-cycle pulse clears seq_error
- seq_error  out  1  sticky address-sequence error

## Operation
- A pixel beat is accepted when pix_valid && pix_ready. The pixel is written to fill-bank slot rel_addr.
- exp_addr is a 3-bit register, reset to 0, set to rel_addr+1 (mod 8) on each accept. An accept with rel_addr != exp_addr sets seq_error. The pixel is still written at rel_addr.
- A group completes on accepting a beat with rel_addr == 7, whatever the earlier slots hold. Unwritten slots read 0: the fill bank clears to 0 whenever its contents move to the output bank.
- group_ctr (INDEX_W bits, reset 0) tags each completed group, then increments. It wraps from GROUPS_PER_FRAME-1 to 0. out_frame_end = (tag == GROUPS_PER_FRAME-1), registered with the group.
- Controller states:
  - EMPTY: output bank empty.
  - ONE: output bank valid, fill bank filling.
  - FULL: output bank valid, fill bank holds a complete group.
- pix_ready = (state != FULL) && neg_reset.
- Let C = group completes this cycle and H = out_valid && out_ready.
  - EMPTY: C -> ONE, fill moves to output.
  - ONE: C&&H -> ONE, fill moves to output. C&&!H -> FULL. !C&&H -> EMPTY. Otherwise stay.
  - FULL: H -> ONE, fill moves to output. No accepts occur in FULL.
- out_valid = (state != EMPTY). out_data, out_group_index and out_frame_end are held stable while out_valid && !out_ready.
- seq_error is set by an error and cleared by clear_error. If both occur in the same cycle, set wins.

## Timing
- Reset (async assert, synchronous-to-clock deassert by system): state EMPTY, out_valid 0, out_data 0, out_group_index 0, out_frame_end 0, seq_error 0, exp_addr 0, group_ctr 0, fill bank 0, pix_ready 0 while neg_reset low.
- Reset mid-group or mid-stall discards all buffered pixels and groups. Next group starts at index 0.
- Latency: slot-7 accept at cycle N -> out_valid = 1 at N+1 (from EMPTY, or ONE with H at N).
- Throughput: one pixel per cycle sustained while out_ready = 1. A group may be presented every 8 cycles.
- Stall: with out_ready = 0, the collector accepts one further full group (8 beats). pix_ready drops at the cycle after the second slot-7 accept.
- Leaving FULL: H at cycle M -> the new group is on out_data at M+1, and pix_ready = 1 at M+1.
- pix_ready depends on registered state only. It has no combinational path from out_ready.

## Test plan
- Reset, then 8 beats rel_addr 0..7 with R=k, G=2k, B=3k, out_ready=1 -> out_valid at cycle 9 only. out_data slot k = {k,2k,3k}. Index 0, seq_error 0.
- out_ready=0, stream 24 beats continuously -> pix_ready falls after beat 16. Group 0 held stable. Raise out_ready -> groups 0, 1, 2 delivered in order with indices 0, 1, 2. No beat lost.
- Beats rel_addr 0,1,3,4,5,6,7 -> seq_error=1 at the beat-3 accept. Slot 2 = 0 in the output. clear_error pulse -> 0. Clear coincident with a new error -> stays 1.
- GROUPS_PER_FRAME=4, stream 5 groups -> indices 0,1,2,3,0. out_frame_end=1 only on the group with index 3.
- In ONE, slot-7 accept and out_ready=1 in the same cycle -> next group presented next cycle, state ONE, no bubble on pix_ready.
- Assert neg_reset in FULL mid-stream -> all outputs 0 immediately (async). After release, a fresh group starts at index 0.
